hvintr: RTL and testbench

HVINTR -- requirements
Module: hvintr

---
 rtl/hvintr.sv | 185 ++++++++++++++++++
 tb/tb_hvintr.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hvintr.sv
// hvintr: VS-level interrupt request arbiter for the hypervisor extension.
// Picks the highest-priority eligible VS interrupt (VSEI > VSSI > VSTI),
// holds a request until the trap unit acks or the source goes away, and
// inserts a one-cycle HOLD after an ack so trap CSR writes settle first.
// Optional feature macro: HVINTR_HGEI_EN (adds the HGEIP port and a
// 2-flop synchronizer feeding VSEI through hstatus.VGEIN).

package hvintr_pkg;
    typedef struct packed {
        int unsigned XLEN;
        logic [1:0]  M_MODE;
        logic [1:0]  S_MODE;
        logic [1:0]  U_MODE;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 64, M_MODE: 2'b11, S_MODE: 2'b01, U_MODE: 2'b00};
endpackage

module hvintr #(
    parameter hvintr_pkg::cvw_t P      = hvintr_pkg::CVW_DEFAULT,
    parameter int unsigned      GEILEN = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [11:0]         HVIP_REGW,
    input  logic [11:0]         MIP_REGW,
    input  logic [11:0]         HIE_REGW,
    input  logic [11:0]         HIDELEG_REGW,
    input  logic [P.XLEN-1:0]   HSTATUS_REGW,
    input  logic                VSSTATUS_SIE,
    input  logic [1:0]          PrivilegeModeW,
    input  logic                VirtModeW,
    input  logic                IntAckM,
`ifdef HVINTR_HGEI_EN
    input  logic [GEILEN-1:0]   HGEIP,
`endif
    output logic                IntReqM,
    output logic [3:0]          IntCauseM,
    output logic                IntTakenM
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [3:0] CAUSE_VSEI = 4'd9;
    localparam logic [3:0] CAUSE_VSSI = 4'd1;
    localparam logic [3:0] CAUSE_VSTI = 4'd5;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_cause;
    logic [3:0]  w_cause_next;
    logic        r_req;
    logic        r_taken;
    logic        w_taken_next;

    logic [11:0] w_pend;
    logic        w_hgei_sel;
    logic        w_elig_ei;
    logic        w_elig_si;
    logic        w_elig_ti;
    logic        w_any_elig;
    logic        w_global_en;
    logic [3:0]  w_winner;
    logic        w_cause_still;
    logic        w_unused;

    // Only a few bits of the CSR inputs matter; fold the rest away.
    assign w_unused = ^{HVIP_REGW, MIP_REGW, HIE_REGW, HIDELEG_REGW, HSTATUS_REGW};

`ifdef HVINTR_HGEI_EN
    logic [GEILEN-1:0] r_sync1;
    logic [GEILEN-1:0] r_sync2;
    logic [5:0]        w_vgein;

    // Two-flop synchronizer for the asynchronous guest external lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= HGEIP;
            r_sync2 <= r_sync1;
        end
    end

    assign w_vgein = HSTATUS_REGW[17:12];

    // VGEIN selects line VGEIN-1; 0 or anything past GEILEN selects nothing.
    always_comb begin
        w_hgei_sel = 1'b0;
        for (int unsigned i = 0; i < GEILEN; i++) begin
            if (w_vgein == 6'(i + 1)) begin
                w_hgei_sel = r_sync2[i];
            end
        end
    end
`else
    assign w_hgei_sel = 1'b0;
`endif

    assign w_pend     = HVIP_REGW | MIP_REGW;
    assign w_elig_ei  = (w_pend[10] | w_hgei_sel) & HIE_REGW[10] & HIDELEG_REGW[10];
    assign w_elig_si  = w_pend[2] & HIE_REGW[2] & HIDELEG_REGW[2];
    assign w_elig_ti  = w_pend[6] & HIE_REGW[6] & HIDELEG_REGW[6];
    assign w_any_elig = w_elig_ei | w_elig_si | w_elig_ti;

    // M-mode and V=0 fall out naturally: neither matches the U/S terms.
    assign w_global_en = VirtModeW &
                         ((PrivilegeModeW == P.U_MODE) |
                          ((PrivilegeModeW == P.S_MODE) & VSSTATUS_SIE));

    // Fixed priority encoder producing the guest-visible cause code.
    always_comb begin
        w_winner = 4'd0;
        if (w_elig_ei) begin
            w_winner = CAUSE_VSEI;
        end else if (w_elig_si) begin
            w_winner = CAUSE_VSSI;
        end else if (w_elig_ti) begin
            w_winner = CAUSE_VSTI;
        end
    end

    // Is the source behind the latched cause still eligible?
    always_comb begin
        w_cause_still = 1'b0;
        case (r_cause)
            CAUSE_VSEI: w_cause_still = w_elig_ei;
            CAUSE_VSSI: w_cause_still = w_elig_si;
            CAUSE_VSTI: w_cause_still = w_elig_ti;
            default:    w_cause_still = 1'b0;
        endcase
    end

    // Next-state logic; ack wins over cancel when both occur in REQ.
    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        w_taken_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_global_en && w_any_elig) begin
                    w_state_next = REQ;
                    w_cause_next = w_winner;
                end
            end
            REQ: begin
                if (IntAckM) begin
                    w_state_next = HOLD;
                    w_taken_next = 1'b1;
                end else if (!w_global_en || !w_cause_still) begin
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cause <= 4'd0;
            r_req   <= 1'b0;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
            r_req   <= (w_state_next == REQ);
            r_taken <= w_taken_next;
        end
    end

    assign IntReqM   = r_req;
    assign IntCauseM = r_cause;
    assign IntTakenM = r_taken;

endmodule

// File: tb/tb_hvintr.sv
// tb_hvintr: directed scenarios plus randomized traffic against a
// behavioural model of the VS interrupt arbiter.
// Build with HVINTR_HGEI_EN defined to exercise the guest external lines.

module tb_hvintr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] hvip;
    logic [11:0] mip;
    logic [11:0] hie;
    logic [11:0] hid;
    logic [63:0] hstatus;
    logic        sie;
    logic [1:0]  priv;
    logic        virt;
    logic        ack;
    logic [7:0]  hgeip;
    logic        int_req;
    logic [3:0]  int_cause;
    logic        int_taken;

    int checks   = 0;
    int failures = 0;

    // Model state: request outstanding, hold bubble, taken pulse, cause.
    bit         m_req;
    bit         m_hold;
    bit         m_taken;
    int         m_cause;
    logic [7:0] m_s1;
    logic [7:0] m_s2;

    always #5 clk = ~clk;

    hvintr dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .HVIP_REGW      (hvip),
        .MIP_REGW       (mip),
        .HIE_REGW       (hie),
        .HIDELEG_REGW   (hid),
        .HSTATUS_REGW   (hstatus),
        .VSSTATUS_SIE   (sie),
        .PrivilegeModeW (priv),
        .VirtModeW      (virt),
        .IntAckM        (ack),
`ifdef HVINTR_HGEI_EN
        .HGEIP          (hgeip),
`endif
        .IntReqM        (int_req),
        .IntCauseM      (int_cause),
        .IntTakenM      (int_taken)
    );

    function automatic logic [11:0] mdl_elig();
        logic [11:0] pend;
`ifdef HVINTR_HGEI_EN
        int vg;
`endif
        pend = hvip | mip;
`ifdef HVINTR_HGEI_EN
        vg = int'(hstatus[17:12]);
        if (vg >= 1 && vg <= 8) begin
            if (m_s2[vg-1]) pend[10] = 1'b1;
        end
`endif
        return pend & hie & hid & 12'h444;
    endfunction

    function automatic bit mdl_ge();
        return virt && (priv == 2'd0 || (priv == 2'd1 && sie));
    endfunction

    function automatic int mdl_pick(input logic [11:0] e);
        if (e[10]) return 9;
        if (e[2])  return 1;
        if (e[6])  return 5;
        return -1;
    endfunction

    task automatic mdl_reset();
        m_req   = 0;
        m_hold  = 0;
        m_taken = 0;
        m_cause = 0;
        m_s1    = '0;
        m_s2    = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic mdl_step();
        logic [11:0] e;
        bit          ge;
        int          w;
        e  = mdl_elig();
        ge = mdl_ge();
        w  = mdl_pick(e);
        m_taken = 0;
        if (m_req) begin
            if (ack) begin
                m_req   = 0;
                m_hold  = 1;
                m_taken = 1;
            end else if (!ge || !e[m_cause+1]) begin
                m_req = 0;
            end
        end else if (m_hold) begin
            m_hold = 0;
        end else if (ge && w >= 0) begin
            m_req   = 1;
            m_cause = w;
        end
        m_s2 = m_s1;
        m_s1 = hgeip;
    endtask

    task automatic tick();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mdl_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_run();
        virt    = 1'b1;
        priv    = 2'd1;
        sie     = 1'b1;
        hie     = 12'h444;
        hid     = 12'h444;
        hvip    = 12'h000;
        mip     = 12'h000;
        ack     = 1'b0;
        hstatus = '0;
        hgeip   = '0;
    endtask

    task automatic test_reset();
        set_run();
        hvip    = 12'h444;
        reset_n = 1'b0;
        mdl_reset();
        #1;
        checks++;
        if ({int_req, int_cause, int_taken} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=000000", {int_req, int_cause, int_taken});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({int_req, int_cause, int_taken} !== 6'b0) begin
            failures++;
            $display("FAIL reset_held got=%b exp=000000", {int_req, int_cause, int_taken});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd9) begin
            failures++;
            $display("FAIL reset_first_edge req=%b cause=%0d exp req=1 cause=9", int_req, int_cause);
        end
    endtask

    task automatic test_basic();
        do_reset();
        set_run();
        hvip = 12'h004;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd1 || int_taken !== 1'b0) begin
            failures++;
            $display("FAIL basic_req req=%b cause=%0d taken=%b exp 1/1/0", int_req, int_cause, int_taken);
        end
        ack = 1'b1;
        tick();
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b1) begin
            failures++;
            $display("FAIL basic_ack req=%b taken=%b exp 0/1", int_req, int_taken);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold req=%b taken=%b exp 0/0", int_req, int_taken);
        end
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd1) begin
            failures++;
            $display("FAIL basic_rereq req=%b cause=%0d exp 1/1", int_req, int_cause);
        end
    endtask

    task automatic test_priority_cancel();
        do_reset();
        set_run();
        hvip = 12'h444;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd9) begin
            failures++;
            $display("FAIL prio_vsei req=%b cause=%0d exp 1/9", int_req, int_cause);
        end
        hvip = 12'h044;
        tick();
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b0) begin
            failures++;
            $display("FAIL prio_cancel req=%b taken=%b exp 0/0", int_req, int_taken);
        end
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd1) begin
            failures++;
            $display("FAIL prio_vssi req=%b cause=%0d exp 1/1", int_req, int_cause);
        end
        hvip = 12'h444;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd1) begin
            failures++;
            $display("FAIL prio_stable req=%b cause=%0d exp 1/1", int_req, int_cause);
        end
        do_reset();
        set_run();
        hvip = 12'h444;
        hid  = 12'h040;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd5) begin
            failures++;
            $display("FAIL prio_deleg_vsti req=%b cause=%0d exp 1/5", int_req, int_cause);
        end
    endtask

    task automatic test_disabled();
        do_reset();
        set_run();
        hvip = 12'h444;
        priv = 2'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                failures++;
                $display("FAIL dis_mmode cyc=%0d req=%b exp 0", i, int_req);
            end
        end
        priv = 2'd1;
        virt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                failures++;
                $display("FAIL dis_v0 cyc=%0d req=%b exp 0", i, int_req);
            end
        end
        virt = 1'b1;
        sie  = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b0) begin
            failures++;
            $display("FAIL dis_sie0 req=%b exp 0", int_req);
        end
        priv = 2'd0;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd9) begin
            failures++;
            $display("FAIL dis_umode req=%b cause=%0d exp 1/9", int_req, int_cause);
        end
    endtask

    task automatic test_ack_cancel();
        do_reset();
        set_run();
        ack  = 1'b1;
        tick();
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle_ignored req=%b taken=%b exp 0/0", int_req, int_taken);
        end
        hvip = 12'h004;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_taken !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle_req req=%b taken=%b exp 1/0", int_req, int_taken);
        end
        hvip = 12'h000;
        tick();
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b1) begin
            failures++;
            $display("FAIL ack_vs_cancel req=%b taken=%b exp 0/1", int_req, int_taken);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b0) begin
            failures++;
            $display("FAIL ack_pulse_width req=%b taken=%b exp 0/0", int_req, int_taken);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_run();
        hvip = 12'h040;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd5) begin
            failures++;
            $display("FAIL rstmid_req req=%b cause=%0d exp 1/5", int_req, int_cause);
        end
        ack = 1'b1;
        #2;
        reset_n = 1'b0;
        mdl_reset();
        #1;
        checks++;
        if (int_req !== 1'b0 || int_taken !== 1'b0 || int_cause !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_drop req=%b taken=%b cause=%0d exp 0/0/0", int_req, int_taken, int_cause);
        end
        @(posedge clk);
        #1;
        checks++;
        if (int_taken !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_taken taken=%b exp 0", int_taken);
        end
        ack     = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd5) begin
            failures++;
            $display("FAIL rstmid_rereq req=%b cause=%0d exp 1/5", int_req, int_cause);
        end
    endtask

`ifdef HVINTR_HGEI_EN
    task automatic test_hgei();
        do_reset();
        set_run();
        hstatus[17:12] = 6'd3;
        hgeip = 8'h04;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (int_req !== (i == 3) || (i == 3 && int_cause !== 4'd9)) begin
                failures++;
                $display("FAIL hgei_latency cyc=%0d req=%b cause=%0d", i, int_req, int_cause);
            end
        end
        do_reset();
        set_run();
        hgeip = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            hstatus[17:12] = (i < 3) ? 6'd0 : 6'd9;
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                failures++;
                $display("FAIL hgei_vgein_oob cyc=%0d req=%b exp 0", i, int_req);
            end
        end
        hstatus[17:12] = 6'd8;
        hgeip = 8'h80;
        tick();
        checks++;
        if (int_req !== 1'b1 || int_cause !== 4'd9) begin
            failures++;
            $display("FAIL hgei_vgein8 req=%b cause=%0d exp 1/9", int_req, int_cause);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        set_run();
        for (int i = 0; i < 3000; i++) begin
            ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                virt    = ($urandom_range(0, 7) != 0);
                priv    = 2'($urandom_range(0, 3));
                sie     = 1'($urandom_range(0, 1));
                hvip    = 12'($urandom) & 12'($urandom);
                mip     = 12'($urandom) & 12'($urandom) & 12'($urandom);
                hie     = ($urandom_range(0, 1) == 0) ? 12'h444 : 12'($urandom);
                hid     = ($urandom_range(0, 1) == 0) ? 12'h444 : 12'($urandom);
                hstatus = {$urandom, $urandom};
                hstatus[17:12] = 6'($urandom_range(0, 10));
                hgeip   = 8'($urandom);
            end
            tick();
            checks++;
            if (int_req !== m_req || int_taken !== m_taken ||
                (m_req && int_cause !== 4'(m_cause))) begin
                failures++;
                $display("FAIL rand cyc=%0d req=%b taken=%b cause=%0d exp req=%b taken=%b cause=%0d",
                         i, int_req, int_taken, int_cause, m_req, m_taken, m_cause);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        set_run();
        mdl_reset();
        test_reset();
        test_basic();
        test_priority_cancel();
        test_disabled();
        test_ack_cancel();
        test_reset_mid();
`ifdef HVINTR_HGEI_EN
        test_hgei();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
